fm_fsk_phase_gen: RTL and testbench
===================================

// Module: fm_fsk_phase_gen
// PURPOSE
// - Transmit-side phase generator for the FM/FSK chain; produces the wrapped phase that phase_unwrap later reconstructs.
// - Accumulates a per-sample phase increment and wraps the result to [-pi, pi) in Q3.13.
// - FM mode takes the increment from fm_incr. FSK mode maps a handshaked bit stream to F0_INC/F1_INC, holding each bit for SYM_LEN samples.
// - Output phase_out feeds the sin/cos LUT ahead of the DAC.
// PARAMETERS
// - PI_Q13   25736  pi in Q3.13 (pi*8192)
// - SYM_LEN  16     samples per FSK symbol, >=2
// - F0_INC   1608   Q3.13 increment for bit 0 (pi/16)
// - F1_INC   3217   Q3.13 increment for bit 1 (pi/8)
// - CNT_W    $clog2(SYM_LEN)  symbol counter width (derived)
// PORTS
// - clk          in   1   clock
// - reset_n      in   1   reset, asynchronous, active-low
// - sample_en    in   1   sample-rate strobe, one clk wide
// - mode         in   1   0=FM, 1=FSK
// - phase_clr    in   1   synchronous accumulator clear
// - fm_incr      in   16  signed Q3.13 increment (FM mode)
// - bit_in       in   1   FSK data bit
// - bit_valid    in   1   bit_in valid
// - bit_ready    out  1   bit accepted on clk edge when bit_valid & bit_ready
// - phase_out    out  16  signed Q3.13 wrapped phase, range [-PI_Q13, PI_Q13)
// - phase_valid  out  1   one-clk pulse, phase_out updated
// - sym_start    out  1   with phase_valid on first sample of each FSK symbol
// - underrun     out  1   one-clk pulse, FSK symbol ended with no bit available
// BEHAVIOUR
// - Reset values: acc, phase_out, cnt and cur_bit = 0; phase_valid, sym_start and underrun = 0; state = IDLE.
// - Wrap arithmetic: 18-bit signed sum s = acc + inc.
//   - s >= PI_Q13  -> s - 2*PI_Q13
//   - s < -PI_Q13  -> s + 2*PI_Q13
//   - one correction suffices because |inc| <= PI_Q13
// - FM: fm_incr is saturated to [-PI_Q13, PI_Q13] before the add.
// - Latency: phase_out and phase_valid register on the edge that samples sample_en high, so there is 1 clk latency. acc and phase_out always hold the same value.
// - FM mode (mode=0): every sample_en advances the phase and pulses phase_valid. State is forced to IDLE and bit_ready=0.
// - FSK states:
//   - IDLE: bit_ready=1, no phase_valid. Accepting a bit sets cur_bit, sets cnt=SYM_LEN-1 and goes to RUN; the first sample follows on the next sample_en.
//   - RUN: each sample_en advances the phase by (cur_bit ? F1_INC : F0_INC) and pulses phase_valid. sym_start=1 on the first sample after a bit load. cnt decrements.
//   - RUN, sample_en with cnt==0: bit_ready=sample_en, combinational.
//     - If bit_valid: load the new bit and cnt=SYM_LEN-1; stay in RUN. This is seamless, continuous phase.
//     - Else: pulse underrun and go to IDLE; acc holds.
// - phase_clr has priority over sample_en in the same clk: acc=0, phase_out=0, no phase_valid that cycle. FSK state and cnt are unaffected.
// - A mode change takes effect on the next clk. FSK->FM drops the current bit with no underrun. Phase stays continuous across a mode change (acc is not cleared).
// - sample_en with mode=1 in IDLE: no output, acc holds.
// - reset_n low mid-symbol: immediate return to reset values; any in-flight bit is lost.
// STRUCTURE
// - Shared package fm_fsk_pkg holds:
//   - PI_Q13 = 25736 and TWO_PI_Q13 = 51472
//   - TWO_PI_Q16 = 411775
//   - Q3.13/Q16.16 width localparams
//   - FSK state enum {IDLE, RUN}
// - One sub-module, phase_wrap_add: combinational 16b+16b add, 18-bit intermediate, single wrap, returns 16b Q3.13.
// - The top holds the FSK FSM, symbol counter, increment mux/saturation and output registers.
// TESTING
// - FM: fm_incr=8192, 4 sample_en from acc=0 -> phase_out 8192, 16384, 24576, -18704; each with phase_valid.
// - FM lower bound: fm_incr=-25736 twice -> -25736, then 0.
// - FM saturation: fm_incr=32767, acc=0 -> phase_out 25736 wraps to -25736.
// - FSK (SYM_LEN=4):
//   - Bits 1 then 0, bit_valid held -> 8 phase_valid pulses, 4x(+3217) then 4x(+1608).
//   - sym_start on pulses 1 and 5; bit_ready high at pulse 4.
//   - No 3rd bit -> one underrun pulse after pulse 8, then no further phase_valid.
// - phase_clr with sample_en in the same clk after acc=5000 -> phase_out=0, phase_valid=0. The next sample with fm_incr=100 gives 100.
// - reset_n pulsed low mid-FSK-symbol -> all outputs 0 immediately. bit_ready=1 after release with mode=1; the next bit restarts with sym_start.

Source files
------------

// File: rtl/fm_fsk_pkg.sv
// Shared constants and types for the FM/FSK transmit phase path.
// Also used by the receive-side phase_unwrap, so pi/2pi live here only once.
package fm_fsk_pkg;

    localparam int PI_Q13     = 25736;
    localparam int TWO_PI_Q13 = 51472;
    localparam int TWO_PI_Q16 = 411775;

    localparam int Q13_W    = 16;
    localparam int Q13_FRAC = 13;
    localparam int Q16_W    = 32;
    localparam int Q16_FRAC = 16;

    // Sum of two Q3.13 values before wrapping
    localparam int SUM_W = Q13_W + 2;

    typedef enum logic {
        IDLE,
        RUN
    } fsk_state_t;

endpackage

// File: rtl/fm_fsk_phase_gen_phase_wrap_add.sv
// Combinational Q3.13 phase add with a single wrap into [-pi, pi).
// One correction is enough because the increment magnitude never exceeds pi.
module phase_wrap_add
    import fm_fsk_pkg::*;
(
    input  logic signed [Q13_W-1:0] i_acc,
    input  logic signed [Q13_W-1:0] i_inc,
    output logic signed [Q13_W-1:0] o_phase
);

    localparam logic signed [SUM_W-1:0] L_PI     = SUM_W'(PI_Q13);
    localparam logic signed [SUM_W-1:0] L_TWO_PI = SUM_W'(TWO_PI_Q13);

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_wrapped;

    always_comb begin
        w_sum = {{(SUM_W-Q13_W){i_acc[Q13_W-1]}}, i_acc}
              + {{(SUM_W-Q13_W){i_inc[Q13_W-1]}}, i_inc};
        if (w_sum >= L_PI)
            w_wrapped = w_sum - L_TWO_PI;
        else if (w_sum < -L_PI)
            w_wrapped = w_sum + L_TWO_PI;
        else
            w_wrapped = w_sum;
        o_phase = w_wrapped[Q13_W-1:0];
    end

endmodule

// File: rtl/fm_fsk_phase_gen.sv
// Transmit phase generator: FM increment accumulation or FSK bit-to-tone mapping,
// wrapped to [-pi, pi) in Q3.13 for the sin/cos LUT.
module fm_fsk_phase_gen
    import fm_fsk_pkg::*;
#(
    parameter int SYM_LEN = 16,
    parameter int F0_INC  = 1608,
    parameter int F1_INC  = 3217,
    parameter int CNT_W   = $clog2(SYM_LEN)
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_en,
    input  logic                    mode,
    input  logic                    phase_clr,
    input  logic signed [Q13_W-1:0] fm_incr,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic signed [Q13_W-1:0] phase_out,
    output logic                    phase_valid,
    output logic                    sym_start,
    output logic                    underrun
);

    localparam logic signed [Q13_W-1:0] L_PI       = Q13_W'(PI_Q13);
    localparam logic signed [Q13_W-1:0] L_F0       = Q13_W'(F0_INC);
    localparam logic signed [Q13_W-1:0] L_F1       = Q13_W'(F1_INC);
    localparam logic [CNT_W-1:0]        L_CNT_LOAD = CNT_W'(SYM_LEN - 1);

    fsk_state_t              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_cur_bit;
    logic                    r_sym_pend;
    logic signed [Q13_W-1:0] r_phase;
    logic                    r_phase_valid;
    logic                    r_sym_start;
    logic                    r_underrun;

    logic                    w_samp;
    logic                    w_sym_end;
    logic signed [Q13_W-1:0] w_fm_sat;
    logic signed [Q13_W-1:0] w_inc;
    logic signed [Q13_W-1:0] w_next_phase;

    // A clear swallows the sample: neither the phase nor the symbol counter advances.
    always_comb begin
        w_samp    = sample_en & ~phase_clr;
        w_sym_end = mode & (r_state == RUN) & w_samp & (r_cnt == '0);
        bit_ready = mode & ((r_state == IDLE) | w_sym_end);

        if (fm_incr > L_PI)
            w_fm_sat = L_PI;
        else if (fm_incr < -L_PI)
            w_fm_sat = -L_PI;
        else
            w_fm_sat = fm_incr;

        if (mode)
            w_inc = r_cur_bit ? L_F1 : L_F0;
        else
            w_inc = w_fm_sat;
    end

    phase_wrap_add u_wrap (
        .i_acc   (r_phase),
        .i_inc   (w_inc),
        .o_phase (w_next_phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cur_bit     <= 1'b0;
            r_sym_pend    <= 1'b0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_sym_start   <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_phase_valid <= 1'b0;
            r_sym_start   <= 1'b0;
            r_underrun    <= 1'b0;

            if (phase_clr) begin
                r_phase <= '0;
            end else if (w_samp && (!mode || r_state == RUN)) begin
                r_phase       <= w_next_phase;
                r_phase_valid <= 1'b1;
            end

            if (!mode) begin
                r_state    <= IDLE;
                r_sym_pend <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bit_valid) begin
                            r_cur_bit  <= bit_in;
                            r_cnt      <= L_CNT_LOAD;
                            r_sym_pend <= 1'b1;
                            r_state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (w_samp) begin
                            r_sym_start <= r_sym_pend;
                            r_sym_pend  <= 1'b0;
                            // Last sample of the symbol still uses the old bit; the next one
                            // is loaded on the same edge so the tone switch is gapless.
                            if (r_cnt == '0) begin
                                if (bit_valid) begin
                                    r_cur_bit  <= bit_in;
                                    r_cnt      <= L_CNT_LOAD;
                                    r_sym_pend <= 1'b1;
                                end else begin
                                    r_underrun <= 1'b1;
                                    r_state    <= IDLE;
                                end
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign phase_out   = r_phase;
    assign phase_valid = r_phase_valid;
    assign sym_start   = r_sym_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_fm_fsk_phase_gen.sv
// Self-checking bench for fm_fsk_phase_gen: directed vectors plus randomized
// FM/FSK traffic against a sample-level reference model.
module tb_fm_fsk_phase_gen;

    localparam int SYM_LEN = 4;
    localparam int PI      = 25736;
    localparam int TWO_PI  = 51472;
    localparam int F0      = 1608;
    localparam int F1      = 3217;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               sample_en;
    logic               mode;
    logic               phase_clr;
    logic signed [15:0] fm_incr;
    logic               bit_in;
    logic               bit_valid;
    logic               bit_ready;
    logic signed [15:0] phase_out;
    logic               phase_valid;
    logic               sym_start;
    logic               underrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase as a plain integer, symbol tracked as samples remaining
    int m_phase;
    int m_left;
    bit m_busy;
    bit m_bit;
    bit m_first;
    bit e_pv;
    bit e_ss;
    bit e_ur;
    bit last_ready;

    always #5 clk = ~clk;

    fm_fsk_phase_gen #(
        .SYM_LEN (SYM_LEN),
        .F0_INC  (F0),
        .F1_INC  (F1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_en   (sample_en),
        .mode        (mode),
        .phase_clr   (phase_clr),
        .fm_incr     (fm_incr),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .sym_start   (sym_start),
        .underrun    (underrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int p);
        int r;
        r = (p + PI) % TWO_PI;
        if (r < 0) r += TWO_PI;
        return r - PI;
    endfunction

    function automatic int sat(input int v);
        return (v > PI) ? PI : ((v < -PI) ? -PI : v);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_busy  = 1'b0;
        m_bit   = 1'b0;
        m_first = 1'b0;
        e_pv    = 1'b0;
        e_ss    = 1'b0;
        e_ur    = 1'b0;
    endtask

    function automatic bit model_ready();
        bit samp;
        samp = sample_en && !phase_clr;
        return mode && (!m_busy || (samp && m_left == 1));
    endfunction

    task automatic model_step();
        bit samp;
        samp = sample_en && !phase_clr;
        e_pv = 1'b0;
        e_ss = 1'b0;
        e_ur = 1'b0;
        if (phase_clr) m_phase = 0;
        if (!mode) begin
            m_busy = 1'b0;
            if (samp) begin
                m_phase = wrap(m_phase + sat(int'(fm_incr)));
                e_pv    = 1'b1;
            end
        end else if (!m_busy) begin
            if (bit_valid) begin
                m_busy  = 1'b1;
                m_bit   = bit_in;
                m_left  = SYM_LEN;
                m_first = 1'b1;
            end
        end else if (samp) begin
            m_phase = wrap(m_phase + (m_bit ? F1 : F0));
            e_pv    = 1'b1;
            e_ss    = m_first;
            m_first = 1'b0;
            m_left--;
            if (m_left == 0) begin
                if (bit_valid) begin
                    m_bit   = bit_in;
                    m_left  = SYM_LEN;
                    m_first = 1'b1;
                end else begin
                    e_ur   = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic tick(input logic se, input logic md, input logic clr,
                        input logic signed [15:0] inc, input logic bi, input logic bv);
        @(negedge clk);
        sample_en = se;
        mode      = md;
        phase_clr = clr;
        fm_incr   = inc;
        bit_in    = bi;
        bit_valid = bv;
        #1;
        last_ready = bit_ready;
        chk("bit_ready", bit_ready, model_ready());
        @(posedge clk);
        model_step();
        #1;
        chk("phase_out", phase_out, m_phase);
        chk("phase_valid", phase_valid, e_pv);
        chk("sym_start", sym_start, e_ss);
        chk("underrun", underrun, e_ur);
    endtask

    initial begin
        int fm_exp[4];
        logic signed [15:0] edge_inc[6];
        logic signed [15:0] inc;
        logic md;

        fm_exp   = '{8192, 16384, 24576, -18704};
        edge_inc = '{16'sh7fff, 16'sh8000, 16'sd25736, -16'sd25736, 16'sd25737, -16'sd25737};

        reset_n   = 1'b0;
        sample_en = 1'b0;
        mode      = 1'b0;
        phase_clr = 1'b0;
        fm_incr   = '0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase_out", phase_out, 0);
        chk("rst_phase_valid", phase_valid, 0);
        chk("rst_sym_start", sym_start, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_bit_ready_fm", bit_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // FM ramp from zero, including the wrap past +pi
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 16'sd8192, 1'b0, 1'b0);
            chk("fm_ramp", phase_out, fm_exp[i]);
            chk("fm_ramp_valid", phase_valid, 1);
        end

        // Lower bound: -pi is representable, -2pi wraps to 0
        tick(1'b0, 1'b0, 1'b1, 16'sd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, -16'sd25736, 1'b0, 1'b0);
        chk("fm_lower_1", phase_out, -25736);
        tick(1'b1, 1'b0, 1'b0, -16'sd25736, 1'b0, 1'b0);
        chk("fm_lower_2", phase_out, 0);

        // Saturated increment lands exactly on +pi and wraps to -pi
        tick(1'b1, 1'b0, 1'b0, 16'sd32767, 1'b0, 1'b0);
        chk("fm_saturate", phase_out, -25736);

        // Clear beats a coincident sample
        tick(1'b0, 1'b0, 1'b1, 16'sd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 16'sd5000, 1'b0, 1'b0);
        chk("clr_pre", phase_out, 5000);
        tick(1'b1, 1'b0, 1'b1, 16'sd1234, 1'b0, 1'b0);
        chk("clr_phase", phase_out, 0);
        chk("clr_valid", phase_valid, 0);
        tick(1'b1, 1'b0, 1'b0, 16'sd100, 1'b0, 1'b0);
        chk("clr_after", phase_out, 100);

        // FSK: bit 1 then bit 0 back to back, then starve
        tick(1'b0, 1'b1, 1'b1, 16'sd0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 16'sd0, 1'b1, 1'b1);
        chk("fsk_load_no_valid", phase_valid, 0);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b1, 1'b0, 16'sd0, 1'b0, (k <= 4));
            chk("fsk_phase", phase_out, (k <= 4) ? k * F1 : 4 * F1 + (k - 4) * F0);
            chk("fsk_valid", phase_valid, 1);
            chk("fsk_sym_start", sym_start, (k == 1 || k == 5));
            chk("fsk_underrun", underrun, (k == 8));
            if (k == 4) chk("fsk_ready_p4", last_ready, 1);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
            chk("fsk_idle_valid", phase_valid, 0);
            chk("fsk_idle_phase", phase_out, 4 * F1 + 4 * F0);
        end

        // Asynchronous reset in the middle of a symbol
        tick(1'b0, 1'b1, 1'b0, 16'sd0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_phase_out", phase_out, 0);
        chk("midrst_phase_valid", phase_valid, 0);
        chk("midrst_sym_start", sym_start, 0);
        chk("midrst_underrun", underrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midrst_bit_ready", bit_ready, 1);
        tick(1'b0, 1'b1, 1'b0, 16'sd0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        chk("midrst_restart_ss", sym_start, 1);
        chk("midrst_restart_phase", phase_out, F0);

        // Randomized FM traffic with clears and boundary increments
        for (int i = 0; i < 200; i++) begin
            inc = 16'($urandom);
            if ($urandom_range(0, 3) == 0) inc = edge_inc[$urandom_range(0, 5)];
            tick(($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 19) == 0),
                 inc, 1'b0, 1'b0);
        end

        // Randomized FSK traffic with occasional mode flips and starvation
        md = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) md = ~md;
            inc = 16'($urandom);
            tick(($urandom_range(0, 2) != 0), md, ($urandom_range(0, 29) == 0),
                 inc, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
